// File: rtl/ram_stream_reader_if.sv
// Handshake/bus bundle for ram_stream_reader: burst control, RAM read port, output stream.
// No latency of its own; it only groups wires.
// Backpressure travels on out_ready; the reader turns it into RAM issue credit.
//
// Signal groups:
//   control : start, start_addr, length -> busy, done
//   RAM     : ram_en, ram_addr -> RAM, ram_rdata <- RAM (READ_LATENCY cycles later)
//   stream  : out_valid, out_data, out_last -> consumer, out_ready <- consumer
//   abort   : abort -> aborted (only when STREAM_READER_ABORT_EN is defined)
// Modports: master = the reader block, slave = the user of the reader (RAM + consumer + controller).

interface ram_stream_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
);
    // Burst control
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;

    // RAM read port
    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Output stream
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

`ifdef STREAM_READER_ABORT_EN
    logic                  abort;
    logic                  aborted;
`endif

    modport master (
        input  start,
        input  start_addr,
        input  length,
        output busy,
        output done,
        output ram_en,
        output ram_addr,
        input  ram_rdata,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
`ifdef STREAM_READER_ABORT_EN
        ,
        input  abort,
        output aborted
`endif
    );

    modport slave (
        output start,
        output start_addr,
        output length,
        input  busy,
        input  done,
        input  ram_en,
        input  ram_addr,
        output ram_rdata,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
`ifdef STREAM_READER_ABORT_EN
        ,
        output abort,
        input  aborted
`endif
    );

endinterface

// File: rtl/ram_stream_reader.sv
// Burst-read engine: streams length words from a block-RAM port starting at start_addr.
// Latency: first out_valid READ_LATENCY cycles after the first ram_en; one word/cycle sustained.
// Backpressure: out_ready stalls the stream; RAM issue is credit-limited so no word is ever dropped.
//
// Ports: clk, rst (async active-high), bus (ram_stream_reader_if.master, see the interface file).
// Optional feature: define STREAM_READER_ABORT_EN to add abort/aborted to the bundle and the
// abort path (stop issue, flush buffer, mask in-flight returns, wait out the RAM pipeline).
// Contains a small generic fall-through FIFO (fifo) used as the output buffer.

// Generic fall-through FIFO.
// Latency: zero when empty (push data is visible on pop side in the same cycle).
// Backpressure: pop_rdy low holds the head; caller must not push when full without popping.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,              // power of two, >= 2
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             pop;
    logic             wr_en;
    logic             rd_adv;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // Empty FIFO lets the incoming word fall straight through to the output.
    assign pop_vld = !empty || push_vld;
    assign pop_dat = empty ? push_dat : mem[rd_ptr];
    assign pop     = pop_vld && pop_rdy;
    // A word that falls through and is taken in the same cycle is never stored.
    assign wr_en   = push_vld && !(empty && pop_rdy);
    assign rd_adv  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
            if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr_en) - CW'(rd_adv);
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

module ram_stream_reader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 2,   // >= 1
    parameter int BUFFER_DEPTH = 4    // power of two, >= READ_LATENCY+1 for full rate
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_stream_reader_if.master  bus
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int OW = $clog2(BUFFER_DEPTH + READ_LATENCY + 1) + 1;
`ifdef STREAM_READER_ABORT_EN
    localparam int WW = $clog2(READ_LATENCY + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
`ifdef STREAM_READER_ABORT_EN
        ,
        S_ABORT
`endif
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           issued_q;
    logic [LW-1:0]           returns_q;
    logic [READ_LATENCY-1:0] inflight_q;
    logic [READ_LATENCY:0]   inflight_sh;
    logic                    done_q;
    logic                    done_d;
    logic                    load;
    logic                    issue;
    logic                    credit;
    logic [OW-1:0]           inflight_cnt;
    logic [OW-1:0]           outstanding;

    logic                    fifo_push;
    logic [DATA_WIDTH:0]     fifo_push_dat;
    logic                    fifo_vld;
    logic [DATA_WIDTH:0]     fifo_dat;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_full;
    logic                    fifo_flush;
    logic                    stream_vld;
    logic                    stream_pop;
    logic                    stream_last;

`ifdef STREAM_READER_ABORT_EN
    logic                    abort_go;
    logic                    aborted_q;
    logic                    aborted_d;
    logic [WW-1:0]           wait_q;
`endif

    // ------------------------------------------------------------------
    // Credit: every issued read owns a buffer slot from issue until pop.
    // Registered in-flight count + registered occupancy; a pop in this
    // cycle frees its slot only from the next cycle on.
    // ------------------------------------------------------------------
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + OW'(inflight_q[i]);
        end
    end

    assign outstanding = inflight_cnt + OW'(fifo_count);
    assign credit      = (outstanding < OW'(BUFFER_DEPTH));

    // ------------------------------------------------------------------
    // Next state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        issue     = 1'b0;
        done_d    = 1'b0;
`ifdef STREAM_READER_ABORT_EN
        abort_go  = 1'b0;
        aborted_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        load    = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        // Empty burst: report completion without ever going busy.
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
`ifdef STREAM_READER_ABORT_EN
                if (bus.abort) begin
                    abort_go = 1'b1;
                    state_d  = S_ABORT;
                end else
`endif
                if (credit) begin
                    issue = 1'b1;
                    if (issued_q + LW'(1) == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
`ifdef STREAM_READER_ABORT_EN
                if (bus.abort) begin
                    abort_go = 1'b1;
                    state_d  = S_ABORT;
                end else
`endif
                if (stream_pop && stream_last) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef STREAM_READER_ABORT_EN
            S_ABORT: begin
                // Reads issued before the abort may still be inside the RAM
                // pipeline; let them pass before accepting a new burst.
                if (wait_q == WW'(READ_LATENCY - 1)) begin
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, address/count registers and in-flight tracking
    // ------------------------------------------------------------------
    // Bit 0 is set the cycle after ram_en; the top bit lines up with ram_rdata.
    assign inflight_sh = {inflight_q, issue};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            returns_q  <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;

            if (fifo_push) returns_q <= returns_q + LW'(1);

            if (load) begin
                addr_q    <= bus.start_addr;
                len_q     <= bus.length;
                issued_q  <= '0;
                returns_q <= '0;
            end else if (issue) begin
                addr_q   <= addr_q + ADDR_WIDTH'(1);   // wraps modulo 2^ADDR_WIDTH
                issued_q <= issued_q + LW'(1);
            end

`ifdef STREAM_READER_ABORT_EN
            if (abort_go) inflight_q <= '0;
            else
`endif
            inflight_q <= inflight_sh[READ_LATENCY-1:0];
        end
    end

`ifdef STREAM_READER_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
            if (abort_go)                wait_q <= '0;
            else if (state_q == S_ABORT) wait_q <= wait_q + WW'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Return path: tag the word whose return count reaches length as last.
    // ------------------------------------------------------------------
    assign fifo_push     = inflight_q[READ_LATENCY-1];
    assign fifo_push_dat = {(returns_q + LW'(1) == len_q), bus.ram_rdata};

`ifdef STREAM_READER_ABORT_EN
    assign fifo_flush = abort_go;
    assign stream_vld = fifo_vld && (state_q != S_ABORT);
`else
    assign fifo_flush = 1'b0;
    assign stream_vld = fifo_vld;
`endif

    assign stream_pop  = stream_vld && bus.out_ready;
    assign stream_last = fifo_dat[DATA_WIDTH];

    fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (BUFFER_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .push_vld (fifo_push),
        .push_dat (fifo_push_dat),
        .pop_rdy  (stream_pop),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat),
        .count    (fifo_count),
        .full     (fifo_full)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.ram_en    = issue;
    assign bus.ram_addr  = addr_q;
    assign bus.out_valid = stream_vld;
    // Data/last are zeroed while idle so the bus shows clean values between bursts.
    assign bus.out_data  = stream_vld ? fifo_dat[DATA_WIDTH-1:0] : '0;
    assign bus.out_last  = stream_vld && stream_last;
`ifdef STREAM_READER_ABORT_EN
    assign bus.aborted   = aborted_q;
`endif

`ifndef SYNTHESIS
    // The credit rule must make a push into a full buffer without a pop impossible.
    always @(posedge clk) begin
        if (!rst) assert (!(fifo_push && fifo_full && !stream_pop));
    end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a latency-2 RAM model (mem[i] = i).
// Expected stream words come from a queue built from start address/length arithmetic.
// Directed bursts cover full rate, stall, address wrap, zero length, mid-burst reset, abort.

module tb_ram_stream_reader;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int RL = 2;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_stream_reader #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .BUFFER_DEPTH (BD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: fixed read latency, not reset, so stale returns keep flowing.
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] pipe [RL];
    logic          pv   [RL];
    always @(posedge clk) begin
        pipe[0] <= mem[bus.ram_addr];
        pv[0]   <= bus.ram_en;
        for (int i = 1; i < RL; i++) begin
            pipe[i] <= pipe[i-1];
            pv[i]   <= pv[i-1];
        end
    end
    assign bus.ram_rdata = pv[RL-1] ? pipe[RL-1] : 64'hDEAD_BEEF_DEAD_BEEF;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: queue of {last, data} words the stream must deliver, in order.
    logic [DW:0] exp_q [$];

    int cyc, en_n, en_first, en_last, busy_n, valid_n, done_n, done_cyc;
    int hs_n, hs_first, hs_last, ab_n;
    logic [63:0] first_dat, last_dat;
    int addr_log [$];

    task automatic clear_counters();
        en_n = 0; en_first = -1; en_last = -1; busy_n = 0; valid_n = 0;
        done_n = 0; done_cyc = -1; hs_n = 0; hs_first = -1; hs_last = -1; ab_n = 0;
        first_dat = '0; last_dat = '0;
        addr_log.delete();
    endtask

    // Compare process: every cycle outside reset, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            logic [DW:0] e;
            cyc++;
            if (bus.ram_en) begin
                en_n++;
                if (en_first < 0) en_first = cyc;
                en_last = cyc;
                addr_log.push_back(int'(bus.ram_addr));
            end
            if (bus.busy)      busy_n++;
            if (bus.out_valid) valid_n++;
            if (bus.done) begin
                done_n++;
                done_cyc = cyc;
`ifdef STREAM_READER_ABORT_EN
                if (bus.aborted) ab_n++;
`endif
            end
            if (bus.out_valid && bus.out_ready) begin
                if (hs_n == 0) begin
                    hs_first  = cyc;
                    first_dat = bus.out_data;
                end
                hs_n++;
                hs_last  = cyc;
                last_dat = bus.out_data;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra: got word %0d, expected no word", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_dat", bus.out_data, e[DW-1:0]);
                    check("stream_last", 64'(bus.out_last), 64'(e[DW]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), 64'((a + i) % (1 << AW))});
        end
        clear_counters();
        bus.start_addr = AW'(a);
        bus.length     = (AW + 1)'(n);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_n == 0; i++) tick();
        check("done_pulses", 64'(done_n), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 64'(i);
        for (int i = 0; i < RL; i++) begin
            pipe[i] = '0;
            pv[i]   = 1'b0;
        end
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;
        bus.out_ready  = 1'b1;
`ifdef STREAM_READER_ABORT_EN
        bus.abort      = 1'b0;
`endif
        cyc = 0;
        clear_counters();

        // Reset values
        tick();
        tick();
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_done",      64'(bus.done),      64'd0);
        check("rst_ram_en",    64'(bus.ram_en),    64'd0);
        check("rst_ram_addr",  64'(bus.ram_addr),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_out_data",  bus.out_data,       64'd0);
        rst = 1'b0;
        tick();

        // Full-rate burst 5..12
        start_burst(5, 8);
        wait_done(50);
        check("t1_en_count",    64'(en_n),              64'd8);
        check("t1_en_span",     64'(en_last - en_first), 64'd7);
        check("t1_first_lat",   64'(hs_first - en_first), 64'(RL));
        check("t1_words",       64'(hs_n),              64'd8);
        check("t1_word_span",   64'(hs_last - hs_first), 64'd7);
        check("t1_done_delay",  64'(done_cyc - hs_last), 64'd1);
        check("t1_busy_cycles", 64'(busy_n),            64'd10);
        check("t1_first_dat",   first_dat,              64'd5);
        check("t1_last_dat",    last_dat,               64'd12);
        check("t1_model_empty", 64'(exp_q.size()),      64'd0);
`ifdef STREAM_READER_ABORT_EN
        check("t1_not_aborted", 64'(ab_n),              64'd0);
`endif
        repeat (3) tick();

        // Stalled consumer: credit stops issue at the buffer depth
        bus.out_ready = 1'b0;
        start_burst(5, 8);
        repeat (10) tick();
        check("t2_stall_issues", 64'(en_n),          64'(BD));
        check("t2_stall_valid",  64'(bus.out_valid), 64'd1);
        check("t2_stall_head",   bus.out_data,       64'd5);
        check("t2_stall_no_hs",  64'(hs_n),          64'd0);
        bus.out_ready = 1'b1;
        wait_done(50);
        check("t2_words",        64'(hs_n),          64'd8);
        check("t2_total_issues", 64'(en_n),          64'd8);
        check("t2_last_dat",     last_dat,           64'd12);
        check("t2_model_empty",  64'(exp_q.size()),  64'd0);
        repeat (3) tick();

        // Address wrap
        start_burst(1022, 4);
        wait_done(50);
        begin
            int exp_addr [4] = '{1022, 1023, 0, 1};
            check("t3_addr_count", 64'(addr_log.size()), 64'd4);
            for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
                check("t3_addr", 64'(addr_log[i]), 64'(exp_addr[i]));
            end
        end
        check("t3_words",       64'(hs_n),         64'd4);
        check("t3_model_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();

        // Zero-length burst
        start_burst(7, 0);
        repeat (5) tick();
        check("t4_done_pulses", 64'(done_n),  64'd1);
        check("t4_busy_cycles", 64'(busy_n),  64'd0);
        check("t4_ram_en",      64'(en_n),    64'd0);
        check("t4_out_valid",   64'(valid_n), 64'd0);
        repeat (2) tick();

        // Reset mid-burst, then a fresh short burst
        start_burst(5, 8);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_busy",   64'(bus.busy),      64'd0);
        check("t5_rst_valid",  64'(bus.out_valid), 64'd0);
        check("t5_rst_ram_en", 64'(bus.ram_en),    64'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        start_burst(100, 2);
        wait_done(50);
        repeat (4) tick();
        check("t5_words",       64'(hs_n),         64'd2);
        check("t5_first_dat",   first_dat,         64'd100);
        check("t5_last_dat",    last_dat,          64'd101);
        check("t5_model_empty", 64'(exp_q.size()), 64'd0);

`ifdef STREAM_READER_ABORT_EN
        // Abort three cycles into a 16-word burst
        repeat (2) tick();
        start_burst(0, 16);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_q.delete();
        for (int i = 0; i < RL + 1; i++) begin
            check("t6_valid_off", 64'(bus.out_valid), 64'd0);
            tick();
        end
        check("t6_done_pulses",  64'(done_n), 64'd1);
        check("t6_aborted_done", 64'(ab_n),   64'd1);
        check("t6_busy_clear",   64'(bus.busy), 64'd0);
        repeat (3) tick();
        check("t6_no_late_done", 64'(done_n), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Sequential burst-read engine on the read side of one port of the team's true-dual-port block RAM.
- Given a start address and word count, it issues back-to-back reads, tracks the RAM's fixed read latency, and buffers returning words in a small FIFO.
- Delivers words on a ready/valid stream, with credit-based issue so consumer backpressure never drops data.
- Used by cache fill/writeback paths and DMA-style copy-out logic.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 64, RAM word width.
- READ_LATENCY, 2, cycles from ram_en to valid ram_rdata (RAM output pipeline depth + 1); must be >= 1.
- BUFFER_DEPTH, 4, output FIFO entries; power of two; must be >= READ_LATENCY+1 for one word per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a burst; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first word address.
- length  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the burst completes.
- ram_en  out  1  read enable to the RAM port (write byte-enables are tied 0 externally).
- ram_addr  out  ADDR_WIDTH  read address.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after ram_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_WIDTH  stream data.
- out_last  out  1  high with the final word of the burst.

Behaviour:
- Reset values: busy=0, done=0, ram_en=0, ram_addr=0, out_valid=0, out_last=0, out_data=0. State is IDLE; all counters, in-flight tracking and the FIFO are cleared.
- States:
  - IDLE: on start with length!=0, latch address and length, go to ISSUE; busy=1 next cycle. On start with length==0, pulse done next cycle and stay in IDLE; busy stays 0.
  - ISSUE: ram_en=1 in any cycle where outstanding < BUFFER_DEPTH, where outstanding = in-flight reads + FIFO occupancy (registered values, excluding the same-cycle pop). On each issue: ram_addr increments with wrap, and issued count increments. When issued == length after an issue, go to DRAIN.
  - DRAIN: no issue. When the last word is accepted (out_valid & out_ready & out_last), pulse done next cycle, clear busy, return to IDLE.
- ram_en/ram_addr are combinational from state and registered address; ram_addr holds its value when ram_en=0.
- In-flight tracking: READ_LATENCY-bit valid shift register. A 1 is pushed on ram_en. When the tail bit is set, ram_rdata is written into the FIFO.
- FIFO: fall-through, out_valid = !empty. Pop on out_valid & out_ready. Simultaneous push and pop is allowed at any occupancy, including full (the credit rule guarantees a push never arrives while full without a pop). Overflow is a design error; the assertion is disabled in synthesis.
- out_last: a returns counter counts FIFO pushes; the word pushed when the count reaches length is tagged last. The tag travels through the FIFO with the data.
- Throughput: one word per cycle with out_ready held high. The first out_valid appears READ_LATENCY cycles after the first ram_en.
- Burst crossing address 2^ADDR_WIDTH-1 wraps to 0. A length of 2^ADDR_WIDTH reads every word exactly once.
- start while busy is ignored.
- rst mid-burst: immediate return to reset values; in-flight RAM returns arriving after reset are discarded (shift register cleared).

Optional Feature:
- Macro: STREAM_READER_ABORT_EN.
- Defined: adds ports abort (in, 1) and aborted (out, 1, reset 0).
  - abort while busy stops issue that cycle, flushes the FIFO, and masks all in-flight returns.
  - The block waits READ_LATENCY cycles for the pipeline to empty, then pulses done together with aborted=1 and returns to IDLE.
  - out_valid is forced 0 from the cycle after abort.
  - abort in IDLE is ignored.
- Undefined: neither port exists and there is no abort path.

Test Plan:
- Params 10/64/2/4; preload mem[i]=i; start_addr=5, length=8, out_ready=1. Expect: ram_en high for 8 consecutive cycles; out_data 5..12 on consecutive cycles; out_last only on 12; done one cycle after the last handshake.
- Same burst with out_ready=0 for 10 cycles. Expect: ram_en stops after 4 issues; out_valid held with out_data=5. After release, all 8 words arrive in order with none lost or duplicated.
- start_addr=1022, length=4. Expect ram_addr 1022, 1023, 0, 1, and data in that order.
- length=0. Expect: done pulse, busy never high, ram_en never high, out_valid never high.
- rst asserted 2 cycles into a length=8 burst, then a new burst with start_addr=100, length=2. Expect: no stale words from the aborted burst; stream delivers exactly 100, 101.
- With STREAM_READER_ABORT_EN: abort 3 cycles into a length=16 burst. Expect: out_valid=0 from the next cycle; done and aborted both pulse within READ_LATENCY+1 cycles; busy returns to 0.
